// File: rtl/bcd_score_accumulator_if.sv
// Score accumulator bus: point events from game logic in, packed-BCD score state out.
// master = game logic / display side, slave = the accumulator.
interface bcd_score_accumulator_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  clear;
    logic                  add_valid;
    logic [3:0]            add_value;
    logic                  add_ready;
    logic                  busy;
    logic [4*DIGITS-1:0]   score_bcd;
    logic [4*DIGITS-1:0]   high_bcd;
    logic                  overflow;
    logic                  new_high;

    modport master (
        output clear, add_valid, add_value,
        input  add_ready, busy, score_bcd, high_bcd, overflow, new_high
    );

    modport slave (
        input  clear, add_valid, add_value,
        output add_ready, busy, score_bcd, high_bcd, overflow, new_high
    );
endinterface

// File: rtl/bcd_score_accumulator.sv
// Packed-BCD score accumulator: adds 0-9 points one digit per clock, with saturate/wrap
// overflow handling and an optional high-score register.
module bcd_score_accumulator #(
    parameter int unsigned DIGITS        = 4,
    parameter bit          SATURATE      = 1'b1,
    parameter bit          HIGH_SCORE_EN = 1'b1
) (
    input  logic                    INPUTCLOCK,
    input  logic                    reset_n,
    bcd_score_accumulator_if.slave  bus
);
    localparam int unsigned       W        = 4 * DIGITS;
    localparam int unsigned       IdxW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0]   LastIdx  = IdxW'(DIGITS - 1);
    localparam logic [W-1:0]      AllNines = {DIGITS{4'h9}};

    typedef enum logic [1:0] {StIdle, StAdd, StCmp} state_e;

    state_e          state_q;
    logic [W-1:0]    work_q;
    logic [3:0]      operand_q;
    logic            carry_q;
    logic [IdxW-1:0] idx_q;
    logic [W-1:0]    score_q;
    logic [W-1:0]    high_q;
    logic            overflow_q;
    logic            new_high_q;

    logic [3:0]      add_clamped;
    logic [3:0]      cur_digit;
    logic [3:0]      digit_operand;
    logic [4:0]      sum;
    logic [4:0]      diff;
    logic [3:0]      new_digit;
    logic            new_carry;
    logic [W-1:0]    work_d;
    int unsigned     base;

    assign add_clamped = (bus.add_value > 4'd9) ? 4'd9 : bus.add_value;

    // Single-digit BCD adder working on the digit selected by idx_q.
    always_comb begin
        base          = 4 * int'(idx_q);
        cur_digit     = work_q[base +: 4];
        digit_operand = (idx_q == '0) ? operand_q : 4'd0;
        sum           = {1'b0, cur_digit} + {1'b0, digit_operand} + {4'b0000, carry_q};
        diff          = sum - 5'd10;
        if (sum > 5'd9) begin
            new_digit = diff[3:0];
            new_carry = 1'b1;
        end else begin
            new_digit = sum[3:0];
            new_carry = 1'b0;
        end
        work_d              = work_q;
        work_d[base +: 4]   = new_digit;
    end

    always_ff @(posedge INPUTCLOCK) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            work_q     <= '0;
            operand_q  <= '0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            score_q    <= '0;
            high_q     <= '0;
            overflow_q <= 1'b0;
            new_high_q <= 1'b0;
        end else begin
            new_high_q <= 1'b0;
            if (bus.clear) begin
                // Clear also aborts an in-flight add without touching the high score.
                state_q    <= StIdle;
                score_q    <= '0;
                overflow_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (bus.add_valid) begin
                            operand_q <= add_clamped;
                            work_q    <= score_q;
                            carry_q   <= 1'b0;
                            idx_q     <= '0;
                            state_q   <= StAdd;
                        end
                    end
                    StAdd: begin
                        work_q  <= work_d;
                        carry_q <= new_carry;
                        idx_q   <= idx_q + IdxW'(1);
                        if (idx_q == LastIdx) begin
                            state_q <= StCmp;
                            if (new_carry) begin
                                overflow_q <= 1'b1;
                                score_q    <= SATURATE ? AllNines : work_d;
                            end else begin
                                score_q    <= work_d;
                            end
                        end
                    end
                    StCmp: begin
                        state_q <= StIdle;
                        if (HIGH_SCORE_EN && (score_q > high_q)) begin
                            high_q     <= score_q;
                            new_high_q <= 1'b1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.add_ready = (state_q == StIdle) && !bus.clear;
    assign bus.busy      = (state_q != StIdle);
    assign bus.score_bcd = score_q;
    assign bus.high_bcd  = HIGH_SCORE_EN ? high_q : '0;
    assign bus.overflow  = overflow_q;
    assign bus.new_high  = HIGH_SCORE_EN ? new_high_q : 1'b0;
endmodule
